// File: rtl/fsm_rx_pkg.sv
// fsm_rx_pkg: shared types and constants for the fsm_rx UART receiver.
//   state_t          - receiver FSM states
//   DATA_BITS        - payload bits per frame (8N1)
//   CLKS_PER_BIT_DEF - default clock cycles per serial bit
package fsm_rx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_rx_if.sv
// fsm_rx_if: serial input and byte-side outputs of the fsm_rx receiver.
//   rx      - serial line, idles high, LSB first
//   Done    - sticky "frame received" level
//   dataout - last correctly framed byte
//   tick    - one-cycle strobe at each bit sample point
//   state   - current receiver FSM state (debug visibility)
// Modports: slave = the receiver, master = whatever drives rx / consumes bytes.
// There is no valid/ready handshake: rx is free-running, and a new byte is
// signalled by Done rising; dataout is stable while Done is high.
interface fsm_rx_if;
    import fsm_rx_pkg::*;

    logic       rx;
    logic       Done;
    logic [7:0] dataout;
    logic       tick;
    state_t     state;

    modport slave  (input rx, output Done, output dataout, output tick, output state);
    modport master (output rx, input Done, input dataout, input tick, input state);
endinterface

// File: rtl/rx_baud_counter.sv
// rx_baud_counter: loadable down-counter that times bit sample points.
//   clk, rst_n - clock, async active-low reset
//   run        - receiver is inside a frame; tick is suppressed otherwise
//   load       - (re)start the count this cycle
//   load_full  - 1: time a full bit period, 0: time to mid start bit
//   tick       - high for one cycle immediately before the sampling edge
module rx_baud_counter #(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic load,
    input  logic load_full,
    output logic tick
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    // The count reaches zero in the cycle before the sampling edge, so a
    // half-period load of HALF_BIT-2 samples HALF_BIT-1 edges after the load,
    // and a full-period load of CLKS_PER_BIT-1 samples CLKS_PER_BIT edges later.
    localparam logic [CW-1:0] LOAD_HALF = CW'(HALF_BIT - 2);
    localparam logic [CW-1:0] LOAD_FULL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_full ? LOAD_FULL : LOAD_HALF;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/fsm_rx.sv
// fsm_rx: 8N1 UART receiver. Samples rx at mid-bit using rx_baud_counter,
// shifts data LSB first, and publishes a byte on dataout with a sticky Done
// level after a good stop bit. A bad stop bit parks in WAIT_IDLE until rx
// returns high.
//   clk, rst_n - clock, async active-low reset
//   bus        - fsm_rx_if.slave (rx in; Done, dataout, tick, state out)
// Build option: RX_SYNC_EN inserts a 2-flop synchronizer (reset to 1) on rx,
// delaying every sample point and Done by 2 cycles.
module fsm_rx
    import fsm_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    fsm_rx_if.slave  bus
);
    logic rx_s;

`ifdef RX_SYNC_EN
    logic rx_meta, rx_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end
    assign rx_s = rx_sync;
`else
    assign rx_s = bus.rx;
`endif

    state_t                 state, state_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic [DATA_BITS-1:0]   dout, dout_nxt;
    logic                   done, done_nxt;
    logic                   run, load, load_full, tick;

    assign run = (state == START) || (state == DATA) || (state == STOP);

    rx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .load      (load),
        .load_full (load_full),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            dout    <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            dout    <= dout_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        dout_nxt    = dout;
        done_nxt    = done;
        load        = 1'b0;
        load_full   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    done_nxt  = 1'b0;
                    load      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                        load        = 1'b1;
                        load_full   = 1'b1;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt[bit_idx] = rx_s;
                    load               = 1'b1;
                    load_full          = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                        dout_nxt  = shreg;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Done    = done;
    assign bus.dataout = dout;
    assign bus.tick    = tick;
    assign bus.state   = state;

endmodule

// File: tb/tb_fsm_rx.sv
// tb_fsm_rx: directed bench for fsm_rx at CLKS_PER_BIT=20 (default build).
module tb_fsm_rx;
  import fsm_rx_pkg::*;

  localparam int CPB = 20;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_rx_if bus();

  fsm_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- monitors ----------------
  int   vecs      = 0;
  int   errs      = 0;
  int   cyc       = 0;
  int   tick_cnt  = 0;
  int   tick_wide = 0;
  int   done_rise = -1;
  logic tick_prev = 1'b0;
  logic done_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tick === 1'b1) tick_cnt++;
    if (bus.tick === 1'b1 && tick_prev === 1'b1) tick_wide++;
    tick_prev = bus.tick;
    if (bus.Done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    done_prev = bus.Done;
  end

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle stamp at which rx fell.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
    bus.rx = 1'b0;
    t0 = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(CPB);
    end
    bus.rx = stop_bit;
    idle(CPB);
  endtask

  // Good frame: Done 190 cycles after the start edge, 10 ticks, byte from scoreboard.
  task automatic good_frame(input string tag, input logic [7:0] b);
    int t0;
    int tb0;
    logic [7:0] exp_b;
    exp_q.push_back(b);
    tb0 = tick_cnt;
    done_rise = -1;
    send_frame(b, 1'b1, t0);
    exp_b = exp_q.pop_front();
    chk({tag, "_dataout"}, 32'(bus.dataout), 32'(exp_b));
    chk({tag, "_done"}, 32'(bus.Done), 32'd1);
    chk({tag, "_ticks"}, 32'(tick_cnt - tb0), 32'd10);
    chk({tag, "_done_lat"}, 32'(done_rise - t0), 32'd190);
    chk({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int tb0;
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    idle(3);
    chk("rst_dataout", 32'(bus.dataout), 32'h00);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    rst_n = 1'b1;
    idle(50);
    chk("idle_ticks", 32'(tick_cnt), 32'd0);
    chk("idle_done", 32'(bus.Done), 32'd0);
    chk("idle_dataout", 32'(bus.dataout), 32'h00);

    // single frame
    good_frame("f19", 8'b0001_1001);
    idle(10);
    chk("f19_done_sticky", 32'(bus.Done), 32'd1);

    // back-to-back: second frame's start edge immediately after the first's stop bit
    good_frame("b2b_19", 8'h19);
    good_frame("b2b_a5", 8'hA5);

    // 4-cycle low glitch on rx in IDLE
    idle(5);
    tb0 = tick_cnt;
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    idle(30);
    chk("glitch_ticks", 32'(tick_cnt - tb0), 32'd1);
    chk("glitch_done", 32'(bus.Done), 32'd0);
    chk("glitch_dataout", 32'(bus.dataout), 32'hA5);
    chk("glitch_state", 32'(bus.state), 32'(IDLE));

    // framing error: stop bit 0
    tb0 = tick_cnt;
    send_frame(8'h3C, 1'b0, t0);
    chk("ferr_done", 32'(bus.Done), 32'd0);
    chk("ferr_dataout", 32'(bus.dataout), 32'hA5);
    chk("ferr_ticks", 32'(tick_cnt - tb0), 32'd10);
    chk("ferr_state", 32'(bus.state), 32'(WAIT_IDLE));
    tb0 = tick_cnt;
    idle(15);
    chk("ferr_hold_state", 32'(bus.state), 32'(WAIT_IDLE));
    chk("ferr_hold_ticks", 32'(tick_cnt - tb0), 32'd0);
    bus.rx = 1'b1;
    idle(3);
    chk("ferr_recover_state", 32'(bus.state), 32'(IDLE));
    good_frame("f55", 8'h55);

    // reset during data bit 4
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b1;
      idle(CPB);
    end
    bus.rx = 1'b0;
    idle(10);
    chk("mid_state_data", 32'(bus.state), 32'(DATA));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dataout", 32'(bus.dataout), 32'h00);
    chk("mid_rst_done", 32'(bus.Done), 32'd0);
    chk("mid_rst_tick", 32'(bus.tick), 32'd0);
    chk("mid_rst_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    idle(5);
    good_frame("ff0", 8'hF0);

    chk("tick_width", 32'(tick_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fsm_rx.md
Name: fsm_rx

Overview:
- UART receiver state machine: 8N1 serial frame on `rx` in, parallel byte out on `dataout`, with a completion flag `Done`.
- Bit timing comes from an internal baud counter. `tick` is the exported sample-point strobe.
- Sits behind the board-level rx pin, in front of byte-consuming logic.

Parameters:
- CLKS_PER_BIT, 20, clock cycles per serial bit. Legal range is 4 and up.
- HALF_BIT, CLKS_PER_BIT/2, derived (localparam), cycles from the start edge to mid-start-bit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line; idles high, LSB first.
- Done  out  1  frame received; level signal, see Behaviour.
- dataout  out  8  last correctly framed byte.
- tick  out  1  one-cycle pulse at each bit sample point.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counters=0, shift register=0.
  - dataout=8'h00, Done=0, tick=0.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx sampled 0 -> go to START, clear counter, clear Done.
  - Otherwise remain; Done and dataout hold.
- START:
  - Count HALF_BIT-1 cycles, then sample rx and pulse tick.
  - rx=0 -> go to DATA, bit index=0, counter=0.
  - rx=1 -> glitch; return to IDLE with no output change (Done stays cleared).
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx at mid-bit and pulse tick.
  - Shift the bit in LSB-first (bit index i -> shreg[i]).
  - After the 8th sample -> go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx and pulse tick.
  - rx=1 -> next cycle dataout=shreg, Done=1, state=IDLE.
  - rx=0 -> framing error: dataout unchanged, Done stays 0, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx=1, then go to IDLE.
- Done:
  - Sticky level, not a pulse.
  - Asserted from the cycle after a good stop sample until the next start edge is accepted in IDLE.
- tick:
  - Exactly 10 pulses per good frame, each exactly one cycle wide.
  - Never asserted in IDLE or WAIT_IDLE.
- Latency (no sync):
  - Falling edge seen at cycle 0; start sample at HALF_BIT-1.
  - Data bit k sampled at HALF_BIT-1+(k+1)*CLKS_PER_BIT.
  - Stop sampled at HALF_BIT-1+9*CLKS_PER_BIT.
  - Done rises one cycle later, i.e. cycle 190 for CLKS_PER_BIT=20, before the stop bit ends.
- Back-to-back frames: a start edge arriving right after the stop sample is accepted from IDLE with no dead cycles beyond one.
- Reset mid-frame: immediate abort to the reset values; the partial byte is discarded.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: rx passes through a 2-flop synchronizer (reset value 1) before the FSM. All sample points and Done shift 2 cycles later.
- Undefined: rx is used directly by the FSM, with the timing above.

Decomposition:
- Package fsm_rx_pkg holds:
  - state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - DATA_BITS=8;
  - default CLKS_PER_BIT=20.
- One natural sub-module: rx_baud_counter.
  - Loadable down-counter.
  - Produces the mid-bit `tick` from a start/restart request and a half/full-period select.
- The FSM stays in fsm_rx.

Test Plan:
- Reset with rx=1, then hold 50 cycles -> dataout=8'h00, Done=0, tick never pulses.
- Send 8'b00011001 at 20 clk/bit -> Done rises ~190 cycles after the start edge and stays high; dataout=8'h19; exactly 10 tick pulses.
- Send 8'h19 then immediately 8'hA5 -> Done drops at the second start edge, re-rises; dataout=8'hA5.
- 4-cycle low glitch on rx in IDLE -> returns to IDLE; no tick after the start check; Done=0; dataout unchanged.
- Frame 8'h3C with stop bit 0 -> Done stays 0; dataout keeps the prior value; FSM waits in WAIT_IDLE until rx=1, then the next frame 8'h55 is received correctly.
- Assert rst_n=0 during data bit 4 -> outputs reset immediately; the following full frame 8'hF0 is received correctly.
